// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage feeding the decode unit. It holds the program
// counter and issues in-order word requests to instruction memory. Each
// returned word is buffered with its address in a small in-order queue, and
// the queue head is offered to decode one instruction per cycle.
//
// Handshakes (both sides use the same rule): a transfer happens in a cycle
// where valid and ready are both high. Valid never depends on ready of the
// same interface. memReqValid_o/memReqReady_i move a request to memory;
// instructionValid_o/decodeReady_i move the queue head to decode.
//
// Ports
//   clock_i               rising-edge clock
//   reset_i               asynchronous active-low reset
//   enable_i              high permits new memory requests
//   redirect_i            flush the queue and restart fetch at redirectAddress_i
//   redirectAddress_i     new PC (two least significant bits are forced to 0)
//   memReqValid_o         request valid
//   memReqAddress_o       request word address (current PC)
//   memReqReady_i         memory accepts the request this cycle
//   memRespValid_i        response valid (in request order, >=1 cycle later)
//   memRespInstruction_i  returned instruction word
//   instructionValid_o    queue head valid to decode
//   instruction_o         queue head instruction
//   instructionAddress_o  queue head address
//   decodeReady_i         decode consumes the head this cycle
module fetch_unit #(
  parameter int unsigned                   instructionWidth = 32,
  parameter int unsigned                   addressSize      = 64,
  parameter logic [0:addressSize-1]        resetAddress     = '0,
  parameter int unsigned                   queueDepth       = 4,
  parameter int unsigned                   queueIndexWidth  = 2
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            enable_i,
  input  logic                            redirect_i,
  input  logic [0:addressSize-1]          redirectAddress_i,
  output logic                            memReqValid_o,
  output logic [0:addressSize-1]          memReqAddress_o,
  input  logic                            memReqReady_i,
  input  logic                            memRespValid_i,
  input  logic [0:instructionWidth-1]     memRespInstruction_i,
  output logic                            instructionValid_o,
  output logic [0:instructionWidth-1]     instruction_o,
  output logic [0:addressSize-1]          instructionAddress_o,
  input  logic                            decodeReady_i
);

  localparam int unsigned CountWidth = queueIndexWidth + 1;

  typedef logic [queueIndexWidth-1:0] ptr_t;
  typedef logic [CountWidth-1:0]      cnt_t;

  localparam logic [0:addressSize-1] PcStep   = addressSize'(4);
  localparam cnt_t                   CountOne = cnt_t'(1);
  localparam cnt_t                   CountMax = cnt_t'(queueDepth);
  localparam ptr_t                   PtrOne   = ptr_t'(1);

  // Program counter and queue storage
  logic [0:addressSize-1]      pc_q, pc_d;
  logic [0:addressSize-1]      addr_q   [queueDepth];
  logic [0:addressSize-1]      addr_d   [queueDepth];
  logic [0:instructionWidth-1] instr_q  [queueDepth];
  logic [0:instructionWidth-1] instr_d  [queueDepth];
  logic [queueDepth-1:0]       filled_q, filled_d;

  // Pointers and counters
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q,  fill_ptr_d;
  ptr_t head_ptr_q,  head_ptr_d;
  cnt_t count_q,     count_d;
  // Allocated entries still waiting for their response.
  cnt_t pending_q,   pending_d;
  // Responses still owed by memory for requests flushed by a redirect.
  cnt_t drop_q,      drop_d;

  logic req_valid;
  logic req_fire;
  logic head_valid;
  logic consume;
  logic resp_drop;
  logic resp_fill;
  cnt_t inflight_total;

  // The two address bits below word granularity are never used.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirectAddress_i[addressSize-2:addressSize-1];

  // Request is held low during reset even though the registers already hold
  // their reset values, so memory never sees a request while reset is low.
  assign req_valid  = reset_i & enable_i & ~redirect_i & (count_q < CountMax);
  assign req_fire   = req_valid & memReqReady_i;
  assign head_valid = filled_q[head_ptr_q] & ~redirect_i;
  assign consume    = head_valid & decodeReady_i;
  assign resp_drop  = memRespValid_i & (drop_q != '0);
  assign resp_fill  = memRespValid_i & (drop_q == '0) & ~redirect_i;

  // Everything memory still owes us; used to size the drop budget on redirect.
  assign inflight_total = drop_q + pending_q;

  // Next-state logic
  always_comb begin
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;
    drop_d      = drop_q;

    if (redirect_i) begin
      pc_d        = {redirectAddress_i[0:addressSize-3], 2'b00};
      for (int i = 0; i < queueDepth; i++) begin
        addr_d[i]  = '0;
        instr_d[i] = '0;
      end
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pending_d   = '0;
      // A response arriving in the redirect cycle is itself discarded, so
      // it no longer counts as owed.
      if (memRespValid_i && (inflight_total != '0)) begin
        drop_d = inflight_total - CountOne;
      end else begin
        drop_d = inflight_total;
      end
    end else begin
      // Allocation, fill and consume always touch different entries:
      // allocation needs a free slot, fill targets an allocated unfilled
      // slot and consume targets a filled slot.
      if (req_fire) begin
        addr_d[alloc_ptr_q]   = pc_q;
        instr_d[alloc_ptr_q]  = '0;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PtrOne;
        pc_d                  = pc_q + PcStep;
      end

      if (resp_fill) begin
        instr_d[fill_ptr_q]  = memRespInstruction_i;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PtrOne;
      end

      if (consume) begin
        addr_d[head_ptr_q]   = '0;
        instr_d[head_ptr_q]  = '0;
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PtrOne;
      end

      if (req_fire && !consume) begin
        count_d = count_q + CountOne;
      end else if (!req_fire && consume) begin
        count_d = count_q - CountOne;
      end

      if (req_fire && !resp_fill) begin
        pending_d = pending_q + CountOne;
      end else if (!req_fire && resp_fill) begin
        pending_d = pending_q - CountOne;
      end

      if (resp_drop) begin
        drop_d = drop_q - CountOne;
      end
    end
  end

  // State registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q        <= resetAddress;
      for (int i = 0; i < queueDepth; i++) begin
        addr_q[i]  <= '0;
        instr_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      drop_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
    end
  end

  // Outputs
  always_comb begin
    memReqValid_o        = req_valid;
    memReqAddress_o      = pc_q;
    instructionValid_o   = head_valid;
    instruction_o        = instr_q[head_ptr_q];
    instructionAddress_o = addr_q[head_ptr_q];
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [63:0] RESET_ADDR = 64'h100;

  // ---------------- clock / reset ----------------
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic        enable_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [0:63] redirectAddress_i = '0;
  logic        memReqValid_o;
  logic [0:63] memReqAddress_o;
  logic        memReqReady_i = 1'b0;
  logic        memRespValid_i = 1'b0;
  logic [0:31] memRespInstruction_i = '0;
  logic        instructionValid_o;
  logic [0:31] instruction_o;
  logic [0:63] instructionAddress_o;
  logic        decodeReady_i = 1'b0;

  fetch_unit #(
    .instructionWidth(32),
    .addressSize(64),
    .resetAddress(RESET_ADDR),
    .queueDepth(4),
    .queueIndexWidth(2)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .redirect_i(redirect_i),
    .redirectAddress_i(redirectAddress_i),
    .memReqValid_o(memReqValid_o),
    .memReqAddress_o(memReqAddress_o),
    .memReqReady_i(memReqReady_i),
    .memRespValid_i(memRespValid_i),
    .memRespInstruction_i(memRespInstruction_i),
    .instructionValid_o(instructionValid_o),
    .instruction_o(instruction_o),
    .instructionAddress_o(instructionAddress_o),
    .decodeReady_i(decodeReady_i)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory model and scoreboard ----------------
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] model_pc = RESET_ADDR;
  int          model_count = 0;
  int          cyc = 0;
  int          lat = 1;

  // Knobs applied at the start of every cycle.
  logic        en_k = 1'b1;
  logic        dr_k = 1'b1;
  logic        rr_k = 1'b1;
  logic        rand_dr = 1'b0;
  logic        rand_rr = 1'b0;
  logic        redir_pend = 1'b0;
  logic [63:0] redir_addr_pend = '0;

  // Observations of the last sampled cycle.
  logic        last_req_valid, last_acc, last_ivalid, last_cons;
  logic [63:0] last_req_addr, last_out_addr;

  task automatic drive();
    mreq_t m;
    redirect_i        = redir_pend;
    redirectAddress_i = redir_addr_pend;
    redir_pend        = 1'b0;
    enable_i          = en_k;
    decodeReady_i     = rand_dr ? 1'($urandom_range(0, 1)) : dr_k;
    memReqReady_i     = rand_rr ? 1'($urandom_range(0, 1)) : rr_k;
    memRespValid_i    = 1'b0;
    memRespInstruction_i = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      memRespValid_i       = 1'b1;
      memRespInstruction_i = mem_word(m.addr);
    end
  endtask

  task automatic sample();
    logic        exp_valid, acc, cons;
    logic [63:0] a, r;
    exp_valid = enable_i & ~redirect_i & (model_count < 4);
    check("req_valid", memReqValid_o == exp_valid, 64'(memReqValid_o), 64'(exp_valid));
    acc  = memReqValid_o & memReqReady_i;
    cons = instructionValid_o & decodeReady_i;
    if (memReqValid_o)
      check("req_addr", memReqAddress_o == model_pc, memReqAddress_o, model_pc);
    if (redirect_i)
      check("redir_no_valid", instructionValid_o == 1'b0, 64'(instructionValid_o), 64'd0);
    if (cons) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1'b0, instructionAddress_o, 64'd0);
      end else begin
        a = exp_q.pop_front();
        check("out_addr", instructionAddress_o == a, instructionAddress_o, a);
        check("out_instr", instruction_o == mem_word(a), 64'(instruction_o), 64'(mem_word(a)));
      end
    end
    if (acc) begin
      mem_q.push_back('{addr: memReqAddress_o, due: cyc + lat});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 64'd4;
    end
    if (redirect_i) begin
      r = redirectAddress_i;
      exp_q.delete();
      model_pc    = r & ~64'h3;
      model_count = 0;
    end else begin
      model_count = model_count + int'(acc) - int'(cons);
    end
    last_req_valid = memReqValid_o;
    last_acc       = acc;
    last_req_addr  = memReqAddress_o;
    last_ivalid    = instructionValid_o;
    last_cons      = cons;
    if (cons) last_out_addr = instructionAddress_o;
  endtask

  task automatic cycle();
    @(posedge clock_i);
    cyc++;
    #1;
    drive();
    @(negedge clock_i);
    sample();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [63:0] a);
    redir_pend      = 1'b1;
    redir_addr_pend = a;
  endtask

  // ---------------- redirect table ----------------
  typedef struct {
    logic [63:0] redir_addr;
    logic [63:0] exp_first;
    logic [63:0] exp_second;
  } vec_t;

  vec_t vecs[4];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int  acc_n;
    logic found;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[1] = '{64'h0000_0000_0000_2003, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_2004};
    vecs[2] = '{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0008};
    vecs[3] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0004};

    // Reset values
    enable_i = 1'b1;
    #23;
    check("rst_req_valid", memReqValid_o == 1'b0, 64'(memReqValid_o), 64'd0);
    check("rst_req_addr", memReqAddress_o == RESET_ADDR, memReqAddress_o, RESET_ADDR);
    check("rst_ivalid", instructionValid_o == 1'b0, 64'(instructionValid_o), 64'd0);
    check("rst_instr", instruction_o == '0, 64'(instruction_o), 64'd0);
    check("rst_iaddr", instructionAddress_o == '0, instructionAddress_o, 64'd0);
    @(negedge clock_i);
    enable_i = 1'b0;
    reset_i  = 1'b1;

    // Test 1: back-to-back fetch from the reset address, 1-cycle memory
    lat = 1; en_k = 1'b1; dr_k = 1'b1; rr_k = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t1_req", last_acc == 1'b1, 64'(last_acc), 64'd1);
      check("t1_req_addr", last_req_addr == RESET_ADDR + 64'(4 * i), last_req_addr,
            RESET_ADDR + 64'(4 * i));
      check("t1_valid", last_ivalid == (i >= 2), 64'(last_ivalid), 64'(i >= 2));
    end

    // Test 2: decode stalled -> exactly four requests, then drain and resume
    dr_k = 1'b0;
    redirect_to(64'h0);
    cycle();
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) acc_n++;
    end
    check("t2_req_count", acc_n == 4, 64'(acc_n), 64'd4);
    check("t2_stalled", last_req_valid == 1'b0, 64'(last_req_valid), 64'd0);
    check("t2_head_valid", last_ivalid == 1'b1, 64'(last_ivalid), 64'd1);
    dr_k  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (last_acc) begin
        found = 1'b1;
        check("t2_resume_addr", last_req_addr == 64'h10, last_req_addr, 64'h10);
      end
    end
    if (!found) check("t2_resume_timeout", 1'b0, 64'd0, 64'd1);
    run(6);

    // Test 3: 3-cycle memory, redirect with three requests in flight
    lat = 3;
    run(10);
    redirect_to(64'h2003);
    cycle();
    cycle();
    check("t3_first_req", last_acc && last_req_addr == 64'h2000, last_req_addr, 64'h2000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (last_cons) begin
        found = 1'b1;
        check("t3_first_out", last_out_addr == 64'h2000, last_out_addr, 64'h2000);
      end
    end
    if (!found) check("t3_out_timeout", 1'b0, 64'd0, 64'd1);

    // Test 4: redirect coincides with a response and with decodeReady_i
    lat = 1;
    run(8);
    redirect_to(64'h3000);
    cycle();
    check("t4_redir_valid", last_ivalid == 1'b0, 64'(last_ivalid), 64'd0);
    check("t4_no_consume", last_cons == 1'b0, 64'(last_cons), 64'd0);
    cycle();
    check("t4_flushed", last_ivalid == 1'b0, 64'(last_ivalid), 64'd0);
    run(4);

    // Test 5: table of redirect targets (low bits masked, PC wrap)
    for (int v = 0; v < 4; v++) begin
      redirect_to(vecs[v].redir_addr);
      cycle();
      cycle();
      check("t5_first", last_acc && last_req_addr == vecs[v].exp_first, last_req_addr,
            vecs[v].exp_first);
      cycle();
      check("t5_second", last_acc && last_req_addr == vecs[v].exp_second, last_req_addr,
            vecs[v].exp_second);
      run(3);
    end

    // Random traffic: random stalls, latencies and redirects
    rand_dr = 1'b1;
    rand_rr = 1'b1;
    for (int blk = 0; blk < 3; blk++) begin
      lat = $urandom_range(1, 3);
      for (int i = 0; i < 100; i++) begin
        en_k = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) redirect_to({$urandom, $urandom});
        cycle();
      end
    end
    rand_dr = 1'b0;
    rand_rr = 1'b0;
    en_k    = 1'b0;
    dr_k    = 1'b1;
    run(20);
    check("drain_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

    // Test 6: asynchronous reset with the queue full
    en_k = 1'b1;
    dr_k = 1'b0;
    lat  = 1;
    run(8);
    check("t6_pre_full", last_ivalid == 1'b1 && model_count == 4, 64'(model_count), 64'd4);
    @(posedge clock_i);
    #3;
    reset_i        = 1'b0;
    memRespValid_i = 1'b0;
    #1;
    check("t6_req_valid", memReqValid_o == 1'b0, 64'(memReqValid_o), 64'd0);
    check("t6_req_addr", memReqAddress_o == RESET_ADDR, memReqAddress_o, RESET_ADDR);
    check("t6_ivalid", instructionValid_o == 1'b0, 64'(instructionValid_o), 64'd0);
    check("t6_instr", instruction_o == '0, 64'(instruction_o), 64'd0);
    check("t6_iaddr", instructionAddress_o == '0, instructionAddress_o, 64'd0);
    mem_q.delete();
    exp_q.delete();
    model_pc    = RESET_ADDR;
    model_count = 0;
    @(posedge clock_i);
    @(negedge clock_i);
    enable_i = 1'b0;
    reset_i  = 1'b1;
    dr_k     = 1'b1;
    cycle();
    check("t6_restart", last_acc && last_req_addr == RESET_ADDR, last_req_addr, RESET_ADDR);
    run(6);
    en_k = 1'b0;
    run(6);
    check("final_drain", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode unit. Holds the program counter and issues in-order word requests to instruction memory. Buffers returned instructions with their addresses in a small in-order queue, and presents one instruction per cycle to decode under a valid/ready handshake. A redirect input (branch resolve or exception) flushes the queue and restarts fetch at a new address; stale in-flight responses are discarded.

## Interface
Parameters:
- instructionWidth, 32, instruction word width
- addressSize, 64, address width
- resetAddress, 64'h0, PC value after reset
- queueDepth, 4, fetch queue entries; power of 2, ≥2
- queueIndexWidth, 2, log2(queueDepth)

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  high permits new memory requests
- redirect_i  in  1  flush and restart fetch
- redirectAddress_i  in  [0:addressSize-1]  new PC; bits [62:63] ignored (forced 0)
- memReqValid_o  out  1  request valid
- memReqAddress_o  out  [0:addressSize-1]  request word address (current PC)
- memReqReady_i  in  1  memory accepts request this cycle
- memRespValid_i  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- memRespInstruction_i  in  [0:instructionWidth-1]  returned word
- instructionValid_o  out  1  head entry valid to decode
- instruction_o  out  [0:instructionWidth-1]  head instruction
- instructionAddress_o  out  [0:addressSize-1]  head instruction address
- decodeReady_i  in  1  decode consumes head this cycle

## Operation
- Queue: queueDepth entries {address, instruction, filled}, allocPtr, fillPtr, headPtr, count (queueIndexWidth+1 bits). Entry allocated at request acceptance (address written, filled=0); filled in order on response; freed when consumed.
- Request: memReqValid_o = enable_i & !redirect_i & (count < queueDepth) & (dropCount == 0 is NOT required). memReqAddress_o = PC. On accept (valid & ready): allocate entry, PC += 4 (wraps modulo 2^addressSize).
- Response: if dropCount > 0, discard and decrement dropCount; else write instruction to entry[fillPtr], set filled, fillPtr++.
- Output: instructionValid_o = entry[headPtr].filled & !redirect_i. Consume on instructionValid_o & decodeReady_i: clear entry, headPtr++, count--.
- Simultaneous allocate and consume in one cycle: count unchanged.
- Redirect (highest priority): PC ← {redirectAddress_i[0:61], 2'b00}; all entries cleared, all pointers and count ← 0; dropCount ← dropCount + (allocated-but-unfilled entries, not counting a response discarded or filled this cycle). No request issued and no consume that cycle. Response arriving in the redirect cycle is discarded (counted against the in-flight total).
- dropCount width queueIndexWidth+1; cannot exceed queueDepth.
- New requests may issue while dropCount > 0; their responses are accepted once dropCount reaches 0 (in-order guarantee).
- enable_i low: no new requests; responses and consumption continue.

## Timing
- Reset (async assert, sync release): PC = resetAddress, queue empty, pointers/count/dropCount = 0, memReqValid_o = 0 while in reset, memReqAddress_o = resetAddress, instructionValid_o = 0, instruction_o = 0, instructionAddress_o = 0.
- First request in first cycle after release with enable_i high.
- Response in cycle N → instructionValid_o high in cycle N+1 (registered fill).
- Fetch-to-decode latency = memory latency + 1 cycle; sustained throughput 1 instruction/cycle when queueDepth ≥ memory latency + 1.
- Redirect in cycle N → first request to new address in cycle N+1.
- Reset mid-operation: all state cleared immediately; pending responses are the memory model's responsibility to cancel.

## Test plan
- Reset release, resetAddress=0x100, 1-cycle memory, decodeReady_i=1 → requests 0x100,0x104,0x108… on consecutive cycles; instruction for 0x100 valid 2 cycles after its request, then one per cycle.
- decodeReady_i=0, 1-cycle memory → exactly 4 requests (0x0–0xC) then memReqValid_o low; raising decodeReady_i drains 0x0 in order and resumes requests at 0x10.
- 3-cycle memory, redirect to 0x2003 with 3 in flight → next request 0x2000; 3 stale responses dropped; first valid output address 0x2000.
- Redirect same cycle as a response and as decodeReady_i → response discarded, no consume, instructionValid_o low that cycle, queue empty next cycle.
- PC at 0xFFFF_FFFF_FFFF_FFFC → next request address 0x0.
- reset_i asserted mid-stream with queue full → outputs immediately at reset values without a clock edge.
